// File: rtl/rv32i_alu.sv
// rv32i_alu: registered 32-bit RV32I execute-stage ALU.
// The result, a dedicated sum and the comparison flags are all registered one
// clock after the operands are sampled.

package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package alufnt;
  typedef enum logic [2:0] {
    add  = 3'd0,
    sl   = 3'd1,
    sra  = 3'd2,
    sub  = 3'd3,
    xoro = 3'd4,
    sr   = 3'd5,
    oro  = 3'd6,
    ando = 3'd7
  } alu_func_t;
endpackage

module rv32i_alu (
  input  logic                  clk,
  input  logic                  rst_n,
  input  alufnt::alu_func_t     fn,
  input  rv32i_types::rv32i_word in1,
  input  rv32i_types::rv32i_word in2,
  output rv32i_types::rv32i_word out,
  output rv32i_types::rv32i_word adder_out,
  output rv32i_types::rv32i_word cmp_out
);

  import rv32i_types::*;

  // Bit reversal lets one right-shifting barrel serve left shifts too.
  function automatic rv32i_word rev32(input rv32i_word v);
    rv32i_word r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Shared add/sub adder: subtract is in1 + ~in2 + 1, carry-out dropped.
  logic      w_is_sub;
  rv32i_word w_addend;
  rv32i_word w_addsub;
  rv32i_word w_sum;

  assign w_is_sub = (fn == alufnt::sub);
  assign w_addend = w_is_sub ? ~in2 : in2;
  assign w_addsub = in1 + w_addend + {31'd0, w_is_sub};
  assign w_sum    = in1 + in2;

  // Barrel shifter: five conditional stages of 1, 2, 4, 8 and 16 bits.
  logic       w_left;
  logic       w_fill;
  logic [4:0] w_shamt;
  rv32i_word  w_sh0;
  rv32i_word  w_sh1;
  rv32i_word  w_sh2;
  rv32i_word  w_sh3;
  rv32i_word  w_sh4;
  rv32i_word  w_sh5;
  rv32i_word  w_shift;

  assign w_left  = (fn == alufnt::sl);
  assign w_fill  = (fn == alufnt::sra) & in1[31];
  assign w_shamt = in2[4:0];
  assign w_sh0   = w_left ? rev32(in1) : in1;
  assign w_sh1   = w_shamt[0] ? {{1{w_fill}},  w_sh0[31:1]}  : w_sh0;
  assign w_sh2   = w_shamt[1] ? {{2{w_fill}},  w_sh1[31:2]}  : w_sh1;
  assign w_sh3   = w_shamt[2] ? {{4{w_fill}},  w_sh2[31:4]}  : w_sh2;
  assign w_sh4   = w_shamt[3] ? {{8{w_fill}},  w_sh3[31:8]}  : w_sh3;
  assign w_sh5   = w_shamt[4] ? {{16{w_fill}}, w_sh4[31:16]} : w_sh4;
  assign w_shift = w_left ? rev32(w_sh5) : w_sh5;

  // Comparison flags: bit0 signed lt, bit1 unsigned lt, bit2 equal.
  logic signed [31:0] w_in1_s;
  logic signed [31:0] w_in2_s;
  rv32i_word          w_cmp;

  assign w_in1_s = in1;
  assign w_in2_s = in2;
  assign w_cmp   = {29'd0, (in1 == in2), (in1 < in2), (w_in1_s < w_in2_s)};

  // Result select for the requested operation.
  rv32i_word w_result;

  always_comb begin
    w_result = w_addsub;
    case (fn)
      alufnt::add,
      alufnt::sub:  w_result = w_addsub;
      alufnt::sl,
      alufnt::sra,
      alufnt::sr:   w_result = w_shift;
      alufnt::xoro: w_result = in1 ^ in2;
      alufnt::oro:  w_result = in1 | in2;
      alufnt::ando: w_result = in1 & in2;
      default:      w_result = w_addsub;
    endcase
  end

  // Output registers; reset clears them immediately and drops any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      adder_out <= '0;
      cmp_out   <= '0;
    end else begin
      out       <= w_result;
      adder_out <= w_sum;
      cmp_out   <= w_cmp;
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// tb_rv32i_alu: scoreboard bench for rv32i_alu with a behavioural reference model.
module tb_rv32i_alu;

  logic              clk;
  logic              rst_n;
  alufnt::alu_func_t fn;
  logic [31:0]       in1;
  logic [31:0]       in2;
  logic [31:0]       out;
  logic [31:0]       adder_out;
  logic [31:0]       cmp_out;

  rv32i_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fn        (fn),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .adder_out (adder_out),
    .cmp_out   (cmp_out)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eo;
    logic [31:0] ea;
    logic [31:0] ec;
  } exp_t;

  exp_t sb[$];
  int   n_pass;
  int   n_chk;
  logic drv_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] ref_out(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    int unsigned sh;
    sa = a;
    sh = b % 32;
    case (f)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return sa >>> sh;
      3'd3: return a - b;
      3'd4: return a ^ b;
      3'd5: return a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    r[0] = ($signed(a) < $signed(b));
    r[1] = (a < b);
    r[2] = (a == b);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one op; expected result from the model unless an explicit value is given.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic use_k = 1'b0, input logic [31:0] k = 32'd0);
    exp_t e;
    @(negedge clk);
    fn      = alufnt::alu_func_t'(f);
    in1     = a;
    in2     = b;
    drv_vld = 1'b1;
    e.f  = f;
    e.a  = a;
    e.b  = b;
    e.eo = use_k ? k : ref_out(f, a, b);
    e.ea = a + b;
    e.ec = ref_cmp(a, b);
    sb.push_back(e);
  endtask

  // Monitor: any edge that sampled a valid op yields a result just after it.
  always @(posedge clk) begin
    if (rst_n && drv_vld) begin
      #1;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: got output %h expected no pending op", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("out f=%0d a=%h b=%h", e.f, e.a, e.b), out, e.eo);
        chk($sformatf("adder_out a=%h b=%h", e.a, e.b), adder_out, e.ea);
        chk($sformatf("cmp_out a=%h b=%h", e.a, e.b), cmp_out, e.ec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pipe_exp [8];
    n_pass  = 0;
    n_chk   = 0;
    drv_vld = 1'b0;
    rst_n   = 1'b0;
    fn      = alufnt::add;
    in1     = 32'd0;
    in2     = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out", out, 32'h0);
    chk("rst_adder", adder_out, 32'h0);
    chk("rst_cmp", cmp_out, 32'h0);

    // Load 5+3, then assert reset mid-cycle and release it.
    rst_n = 1'b1;
    fn    = alufnt::add;
    in1   = 32'd5;
    in2   = 32'd3;
    @(posedge clk);
    #1;
    chk("load_out", out, 32'd8);
    chk("load_adder", adder_out, 32'd8);
    chk("load_cmp", cmp_out, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 32'h0);
    chk("async_rst_adder", adder_out, 32'h0);
    chk("async_rst_cmp", cmp_out, 32'h0);
    @(negedge clk);
    chk("rst_hold_out", out, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out", out, 32'd8);

    // Exhaustive small sweep.
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        for (int f = 0; f < 8; f++)
          issue(3'(f), 32'(a), 32'(b));

    // Worked example a=9, b=3 against literal values.
    issue(3'd0, 32'd9, 32'd3, 1'b1, 32'd12);
    issue(3'd1, 32'd9, 32'd3, 1'b1, 32'd72);
    issue(3'd2, 32'd9, 32'd3, 1'b1, 32'd1);
    issue(3'd3, 32'd9, 32'd3, 1'b1, 32'd6);
    issue(3'd4, 32'd9, 32'd3, 1'b1, 32'd10);
    issue(3'd5, 32'd9, 32'd3, 1'b1, 32'd1);
    issue(3'd6, 32'd9, 32'd3, 1'b1, 32'd11);
    issue(3'd7, 32'd9, 32'd3, 1'b1, 32'd1);

    // Wrap, sign, shift boundaries and compare flags with literal results.
    issue(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0);
    issue(3'd3, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFE);
    issue(3'd3, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF);
    issue(3'd5, 32'h8000_0000, 32'd31, 1'b1, 32'h1);
    issue(3'd1, 32'h0000_0001, 32'd31, 1'b1, 32'h8000_0000);
    issue(3'd2, 32'h8000_0000, 32'h20, 1'b1, 32'h8000_0000);
    issue(3'd5, 32'h8000_0000, 32'h20, 1'b1, 32'h8000_0000);
    issue(3'd1, 32'h8000_0000, 32'h20, 1'b1, 32'h8000_0000);
    issue(3'd0, 32'h1, 32'hFFFF_FFFF);
    issue(3'd4, 32'd7, 32'd7);

    // Back-to-back fn changes with fixed operands 12 and 10.
    pipe_exp = '{32'd22, 32'd12288, 32'd0, 32'd2, 32'd6, 32'd0, 32'd14, 32'd8};
    for (int f = 0; f < 8; f++)
      issue(3'(f), 32'd12, 32'd10, 1'b1, pipe_exp[f]);

    // Random operands, including sign-heavy values.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = a;
      if (i % 5 == 0) a = a | 32'h8000_0000;
      issue(3'($urandom_range(0, 7)), a, b);
    end

    @(negedge clk);
    drv_vld = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    // Direct compare-flag checks on the held registers.
    @(negedge clk);
    fn = alufnt::add; in1 = 32'hFFFF_FFFF; in2 = 32'd1;
    @(posedge clk); #1;
    chk("cmp_signed_only", cmp_out, 32'd1);
    chk("adder_wrap", adder_out, 32'd0);
    @(negedge clk);
    in1 = 32'd1; in2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("cmp_unsigned_only", cmp_out, 32'd2);
    @(negedge clk);
    in1 = 32'd7; in2 = 32'd7;
    @(posedge clk); #1;
    chk("cmp_equal", cmp_out, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
